// File: rtl/mcu_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit RISC MCU.
// Owns the PC and IR; all strobes are Moore outputs of state and IR.
module mcu_control_unit #(
  parameter int PC_WIDTH = 8,
  parameter int TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                mem_ready,
  input  logic [15:0]         instr,
  input  logic                flag_z,
  input  logic                flag_c,
  output logic [PC_WIDTH-1:0] pc,
  output logic [15:0]         ir,
  output logic                mem_req,
  output logic                mem_sel,
  output logic                mem_we,
  output logic [2:0]          alu_op,
  output logic                rf_we,
  output logic [1:0]          rf_wsel,
  output logic                out_we,
  output logic                halted,
  output logic                bus_err,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  state_e     state_q;
  state_e     state_d;
  state_e     end_st;
  logic [7:0] wait_cnt;
  logic [3:0] opc;
  logic       op_alu, op_ldi, op_ld, op_st;
  logic       op_in, op_out, op_jmp, op_jz;
  logic       op_jc, op_hlt;
  logic       waiting;
  logic       tmo;
  logic       take_jmp;

  assign opc    = ir[15:12];
  assign op_alu = (opc == 4'h1);
  assign op_ldi = (opc == 4'h2);
  assign op_ld  = (opc == 4'h3);
  assign op_st  = (opc == 4'h4);
  assign op_in  = (opc == 4'h5);
  assign op_out = (opc == 4'h6);
  assign op_jmp = (opc == 4'h7);
  assign op_jz  = (opc == 4'h8);
  assign op_jc  = (opc == 4'h9);
  assign op_hlt = (opc == 4'hF);

  assign take_jmp = op_jmp
                  | (op_jz & flag_z)
                  | (op_jc & flag_c);

  assign waiting = (state_q == S_FETCH)
                 | (state_q == S_MEM);
  // ready on the limit cycle still completes
  assign tmo = waiting & ~mem_ready
             & (wait_cnt == LIMIT);

  assign end_st = run ? S_FETCH : S_IDLE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
        else if (tmo) state_d = S_HALT;
      end
      S_DECODE: begin
        unique case (1'b1)
          op_hlt:         state_d = S_HALT;
          (op_ld | op_st): state_d = S_MEM;
          default:        state_d = S_EXEC;
        endcase
      end
      S_EXEC: state_d = end_st;
      S_MEM: begin
        if (mem_ready) state_d = op_ld ? S_WB : end_st;
        else if (tmo) state_d = S_HALT;
      end
      S_WB:   state_d = end_st;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= '0;
      ir       <= '0;
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      if (state_q == S_FETCH && mem_ready) begin
        ir <= instr;
        pc <= pc + 1'b1;
      end else if (state_q == S_EXEC && take_jmp) begin
        pc <= ir[PC_WIDTH-1:0];
      end
      if (state_d != state_q) begin
        wait_cnt <= '0;
      end else if (waiting) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (tmo) bus_err <= 1'b1;
    end
  end

  always_comb begin
    mem_req = 1'b0;
    mem_sel = 1'b0;
    mem_we  = 1'b0;
    alu_op  = 3'd0;
    rf_we   = 1'b0;
    rf_wsel = 2'd0;
    out_we  = 1'b0;
    halted  = 1'b0;
    unique case (state_q)
      S_FETCH: mem_req = 1'b1;
      S_MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = op_st;
      end
      S_EXEC: begin
        unique case (1'b1)
          op_alu: begin
            rf_we  = 1'b1;
            alu_op = ir[11:9];
          end
          op_ldi: begin
            rf_we   = 1'b1;
            rf_wsel = 2'd3;
          end
          op_in: begin
            rf_we   = 1'b1;
            rf_wsel = 2'd2;
          end
          op_out:  out_we = 1'b1;
          default: ;
        endcase
      end
      S_WB: begin
        rf_we   = 1'b1;
        rf_wsel = 2'd1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_mcu_control_unit.sv
// Directed bench for mcu_control_unit with a small wait-state memory model.
// Outputs are sampled and memory inputs driven on the falling edge.
module tb_mcu_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        mem_ready;
  logic [15:0] instr;
  logic        flag_z;
  logic        flag_c;
  logic [7:0]  pc;
  logic [15:0] ir;
  logic        mem_req, mem_sel, mem_we;
  logic [2:0]  alu_op;
  logic        rf_we;
  logic [1:0]  rf_wsel;
  logic        out_we, halted, bus_err;
  logic [2:0]  state;

  mcu_control_unit #(.PC_WIDTH(8), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .run(run),
    .mem_ready(mem_ready), .instr(instr),
    .flag_z(flag_z), .flag_c(flag_c),
    .pc(pc), .ir(ir),
    .mem_req(mem_req), .mem_sel(mem_sel),
    .mem_we(mem_we), .alu_op(alu_op),
    .rf_we(rf_we), .rf_wsel(rf_wsel),
    .out_we(out_we), .halted(halted),
    .bus_err(bus_err), .state(state)
  );

  always #5 clk = ~clk;

  logic [15:0] imem [256];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc;
  int fwait, dwait, wcnt;
  logic [2:0] prev_st;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  // memory answers after fwait/dwait stall cycles per request
  task automatic upd_mem();
    int lim;
    if (state != prev_st) wcnt = 0;
    prev_st = state;
    if (mem_req) begin
      lim = mem_sel ? dwait : fwait;
      mem_ready = (wcnt >= lim);
      wcnt++;
    end else begin
      mem_ready = 1'b0;
    end
    instr = imem[pc];
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    upd_mem();
  endtask

  task automatic clr_mem();
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    fwait = 0;
    dwait = 0;
    flag_z = 1'b0;
    flag_c = 1'b0;
  endtask

  task automatic do_reset(input logic r);
    run = r;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    prev_st = 3'd7;
    upd_mem();
  endtask

  function automatic logic [7:0] strobes();
    return {mem_req, mem_sel, mem_we, rf_we,
            out_we, halted, bus_err, |rf_wsel};
  endfunction

  task automatic exec_one(input logic [15:0] w);
    clr_mem();
    imem[0] = w;
    do_reset(1'b1);
    repeat (3) tick();
  endtask

  task automatic jump_one(input logic [15:0] w,
                          input logic z, input logic c,
                          input logic [7:0] exp_pc,
                          input string tag);
    clr_mem();
    imem[0] = w;
    flag_z = z;
    flag_c = c;
    do_reset(1'b1);
    repeat (4) tick();
    chk({tag, "_st"}, state, 3'd1);
    chk({tag, "_pc"}, pc, exp_pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] exp_st [10];
    exp_st = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd2,
               3'd3, 3'd1, 3'd2, 3'd6, 3'd6};
    reset = 1'b0;
    run = 1'b1;
    mem_ready = 1'b0;
    instr = 16'h0;
    cyc = 0;
    clr_mem();
    repeat (2) @(negedge clk);
    chk("rst_state", state, 3'd0);
    chk("rst_pc", pc, 8'd0);
    chk("rst_ir", ir, 16'd0);
    chk("rst_strobes", strobes(), 8'd0);
    chk("rst_alu", alu_op, 3'd0);

    // LDI / OUT / HLT program
    imem[0] = 16'h2005;
    imem[1] = 16'h6000;
    imem[2] = 16'hF000;
    do_reset(1'b1);
    chk("p_idle", state, 3'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("p_st%0d", cyc), state, exp_st[i]);
      if (cyc == 3) begin
        chk("ldi_we", rf_we, 1'b1);
        chk("ldi_wsel", rf_wsel, 2'd3);
      end
      if (cyc == 6) chk("out_we", out_we, 1'b1);
      if (cyc == 5) chk("out_we_pre", out_we, 1'b0);
    end
    chk("hlt_halted", halted, 1'b1);
    chk("hlt_pc", pc, 8'd3);
    chk("hlt_req", mem_req, 1'b0);
    chk("hlt_err", bus_err, 1'b0);

    // LD at pc 4 with 3 memory stall cycles
    clr_mem();
    imem[0] = 16'h7004;
    imem[4] = 16'h3000;
    dwait = 3;
    do_reset(1'b1);
    repeat (4) tick();
    chk("ld_fetch_pc", pc, 8'd4);
    tick();
    chk("ld_dec", state, 3'd2);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("ld_mem%0d", i),
          {state, mem_req, mem_sel, mem_we},
          {3'd4, 1'b1, 1'b1, 1'b0});
    end
    tick();
    chk("ld_wb", {state, rf_we, rf_wsel},
        {3'd5, 1'b1, 2'd1});
    tick();
    chk("ld_next", state, 3'd1);
    chk("ld_next_pc", pc, 8'd5);

    // single-cycle EXEC decodes
    exec_one(16'h1A00);
    chk("alu_st", state, 3'd3);
    chk("alu_out", {rf_we, rf_wsel, alu_op},
        {1'b1, 2'd0, 3'd5});
    exec_one(16'h5000);
    chk("in_out", {rf_we, rf_wsel, alu_op},
        {1'b1, 2'd2, 3'd0});
    exec_one(16'hBE00);
    chk("nopx_st", state, 3'd3);
    chk("nopx_out", strobes(), 8'd0);
    chk("nopx_alu", alu_op, 3'd0);

    // conditional jumps
    jump_one(16'h8010, 1'b1, 1'b0, 8'h10, "jz_t");
    jump_one(16'h8010, 1'b0, 1'b1, 8'h01, "jz_n");
    jump_one(16'h9020, 1'b0, 1'b1, 8'h20, "jc_t");
    jump_one(16'h9020, 1'b1, 1'b0, 8'h01, "jc_n");
    jump_one(16'h7033, 1'b0, 1'b0, 8'h33, "jmp");

    // fetch timeout
    clr_mem();
    fwait = 255;
    do_reset(1'b1);
    repeat (15) tick();
    chk("tmo_pre", {state, bus_err}, {3'd1, 1'b0});
    tick();
    chk("tmo_halt", {halted, bus_err}, 2'b11);
    chk("tmo_req", mem_req, 1'b0);
    repeat (3) tick();
    chk("tmo_stick", {state, bus_err}, {3'd6, 1'b1});

    // ready on the limit cycle wins
    clr_mem();
    fwait = 14;
    do_reset(1'b1);
    repeat (16) tick();
    chk("lim_dec", {state, bus_err}, {3'd2, 1'b0});

    // run dropped during ST
    clr_mem();
    imem[0] = 16'h4000;
    dwait = 2;
    do_reset(1'b1);
    repeat (3) tick();
    chk("st_mem", {state, mem_req, mem_sel, mem_we},
        {3'd4, 3'b111});
    run = 1'b0;
    tick();
    chk("st_mem2", mem_we, 1'b1);
    tick();
    chk("st_mem3", {mem_we, mem_ready}, 2'b11);
    tick();
    chk("st_idle", {state, mem_req}, {3'd0, 1'b0});
    chk("st_pc", pc, 8'd1);
    repeat (2) tick();
    chk("st_stay", state, 3'd0);
    run = 1'b1;
    tick();
    chk("st_refetch", {state, pc}, {3'd1, 8'd1});

    // async reset mid-store
    clr_mem();
    imem[0] = 16'h4000;
    dwait = 255;
    do_reset(1'b1);
    repeat (3) tick();
    chk("ar_pre", mem_we, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("ar_strobes", strobes(), 8'd0);
    chk("ar_pc_st", {pc, state}, {8'd0, 3'd0});
    chk("ar_ir", ir, 16'd0);

    // PC wrap
    clr_mem();
    imem[0] = 16'h70FF;
    do_reset(1'b1);
    repeat (4) tick();
    chk("wrap_ff", pc, 8'hFF);
    tick();
    chk("wrap_00", {state, pc}, {3'd2, 8'h00});
    repeat (2) tick();
    chk("wrap_fetch", {state, pc}, {3'd1, 8'h00});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
